// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types and defaults for the two-master Wishbone arbiter.
//   arb_state_t            - arbiter FSM encoding (IDLE, GRANT0, GRANT1)
//   master_id_t            - identifies one of the two masters
//   DEFAULT_TIMEOUT_CYCLES - default watchdog limit (only used with WB_ARB_TIMEOUT_EN)
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  typedef logic master_id_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/wb_arb_timeout.sv
// wb_arb_timeout: slave watchdog for the arbiter. Counts clocks in which the
// granted master is strobing and the slave has not answered.
//   clk     in  clock
//   rst     in  asynchronous, active-high reset
//   run     in  count this cycle (granted, STB high, no ACK/ERR)
//   clr     in  restart the count (ACK, ERR or grant change)
//   expired out count has reached TIMEOUT_CYCLES; holds for exactly one cycle
// Only instantiated when WB_ARB_TIMEOUT_EN is defined.
module wb_arb_timeout
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count_q;

  assign expired = (count_q == LIMIT);

  // The count self-clears in the cycle it expires, so the error is a single
  // cycle pulse and the count never passes LIMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr || expired) begin
      count_q <= '0;
    end else if (run) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master Wishbone classic arbiter, round-robin at cycle
// granularity. The owner keeps the grant for as long as it holds CYC.
//   CLK_I, RST_I                 clock, asynchronous active-high reset
//   Mx_CYC_I/STB_I/WE_I/ADR_I/DAT_I/SEL_I  master x request (x = 0, 1)
//   Mx_DAT_O                     read data (S_DAT_I broadcast)
//   Mx_ACK_O, Mx_ERR_O           slave response, routed to the owner only
//   S_CYC_O/STB_O/WE_O/ADR_O/DAT_O/SEL_O   muxed from the granted master
//   S_DAT_I, S_ACK_I, S_ERR_I    slave read data and response
//   dbg_state                    current arbiter state (observation only)
// Optional feature: define WB_ARB_TIMEOUT_EN to add a slave watchdog that
// answers a stalled cycle with a one-cycle ERR after TIMEOUT_CYCLES clocks.
//
// Handshake: CYC&STB from the owner is the request (valid); ACK or ERR from
// the slave completes it (ready). A master keeps CYC/STB stable until ACK/ERR,
// one cycle is in flight at a time, and there is no STALL.
module wb_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_BUS_WIDTH   = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                      CLK_I,
  input  logic                      RST_I,
  input  logic                      M0_CYC_I,
  input  logic                      M0_STB_I,
  input  logic                      M0_WE_I,
  input  logic [WB_ADDR_WIDTH-1:0]  M0_ADR_I,
  input  logic [WB_BUS_WIDTH-1:0]   M0_DAT_I,
  input  logic [WB_BUS_WIDTH/8-1:0] M0_SEL_I,
  output logic [WB_BUS_WIDTH-1:0]   M0_DAT_O,
  output logic                      M0_ACK_O,
  output logic                      M0_ERR_O,
  input  logic                      M1_CYC_I,
  input  logic                      M1_STB_I,
  input  logic                      M1_WE_I,
  input  logic [WB_ADDR_WIDTH-1:0]  M1_ADR_I,
  input  logic [WB_BUS_WIDTH-1:0]   M1_DAT_I,
  input  logic [WB_BUS_WIDTH/8-1:0] M1_SEL_I,
  output logic [WB_BUS_WIDTH-1:0]   M1_DAT_O,
  output logic                      M1_ACK_O,
  output logic                      M1_ERR_O,
  output logic                      S_CYC_O,
  output logic                      S_STB_O,
  output logic                      S_WE_O,
  output logic [WB_ADDR_WIDTH-1:0]  S_ADR_O,
  output logic [WB_BUS_WIDTH-1:0]   S_DAT_O,
  output logic [WB_BUS_WIDTH/8-1:0] S_SEL_O,
  input  logic [WB_BUS_WIDTH-1:0]   S_DAT_I,
  input  logic                      S_ACK_I,
  input  logic                      S_ERR_I,
  output arb_state_t                dbg_state
);

  arb_state_t state_q, state_d;
  master_id_t last_q, last_d;
  logic       grant0, grant1;
  logic       mux_cyc, mux_stb;
  logic       expired;

  // last resets to 1 so master 0 wins the first tie.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (M0_CYC_I && M1_CYC_I) begin
          state_d = (last_q == 1'b1) ? GRANT0 : GRANT1;
        end else if (M0_CYC_I) begin
          state_d = GRANT0;
        end else if (M1_CYC_I) begin
          state_d = GRANT1;
        end
      end
      GRANT0: begin
        // Hand over straight to a waiting master: no idle cycle in between.
        if (!M0_CYC_I) begin
          state_d = M1_CYC_I ? GRANT1 : IDLE;
          last_d  = 1'b0;
        end
      end
      GRANT1: begin
        if (!M1_CYC_I) begin
          state_d = M0_CYC_I ? GRANT0 : IDLE;
          last_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant0    = (state_q == GRANT0);
  assign grant1    = (state_q == GRANT1);
  assign dbg_state = state_q;

  // Slave-side mux from the registered grant; everything is zero in IDLE.
  always_comb begin
    mux_cyc = 1'b0;
    mux_stb = 1'b0;
    S_WE_O  = 1'b0;
    S_ADR_O = '0;
    S_DAT_O = '0;
    S_SEL_O = '0;
    if (grant0) begin
      mux_cyc = M0_CYC_I;
      mux_stb = M0_STB_I;
      S_WE_O  = M0_WE_I;
      S_ADR_O = M0_ADR_I;
      S_DAT_O = M0_DAT_I;
      S_SEL_O = M0_SEL_I;
    end else if (grant1) begin
      mux_cyc = M1_CYC_I;
      mux_stb = M1_STB_I;
      S_WE_O  = M1_WE_I;
      S_ADR_O = M1_ADR_I;
      S_DAT_O = M1_DAT_I;
      S_SEL_O = M1_SEL_I;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic to_run, to_clr;
  assign to_run = (grant0 || grant1) && mux_stb && !S_ACK_I && !S_ERR_I;
  assign to_clr = S_ACK_I || S_ERR_I || (state_d != state_q);

  wb_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (CLK_I),
    .rst    (RST_I),
    .run    (to_run),
    .clr    (to_clr),
    .expired(expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign expired = 1'b0;
`endif

  // An expired watchdog withdraws the cycle from the slave for one clock while
  // the owner sees ERR.
  assign S_CYC_O = mux_cyc && !expired;
  assign S_STB_O = mux_stb && !expired;

  assign M0_ACK_O = grant0 && S_ACK_I && !expired;
  assign M1_ACK_O = grant1 && S_ACK_I && !expired;
  assign M0_ERR_O = grant0 && (S_ERR_I || expired);
  assign M1_ERR_O = grant1 && (S_ERR_I || expired);

  assign M0_DAT_O = S_DAT_I;
  assign M1_DAT_O = S_DAT_I;

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: self-checking bench for wb_arbiter2 (TIMEOUT_CYCLES = 4).
module tb_wb_arbiter2;
  import wb_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT connections ----------------
  logic [1:0]    m_cyc, m_stb, m_we;
  logic [AW-1:0] m_adr [2];
  logic [DW-1:0] m_wdat [2];
  logic [SW-1:0] m_sel [2];
  logic [DW-1:0] m0_rdat, m1_rdat;
  logic          m0_ack, m1_ack, m0_err, m1_err;
  logic          s_cyc, s_stb, s_we;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_dat, s_rdat;
  logic [SW-1:0] s_sel;
  logic          s_ack, s_err;
  arb_state_t    dbg_state;

  wb_arbiter2 #(
    .WB_ADDR_WIDTH(AW), .WB_BUS_WIDTH(DW), .TIMEOUT_CYCLES(4)
  ) dut (
    .CLK_I(clk), .RST_I(rst),
    .M0_CYC_I(m_cyc[0]), .M0_STB_I(m_stb[0]), .M0_WE_I(m_we[0]),
    .M0_ADR_I(m_adr[0]), .M0_DAT_I(m_wdat[0]), .M0_SEL_I(m_sel[0]),
    .M0_DAT_O(m0_rdat), .M0_ACK_O(m0_ack), .M0_ERR_O(m0_err),
    .M1_CYC_I(m_cyc[1]), .M1_STB_I(m_stb[1]), .M1_WE_I(m_we[1]),
    .M1_ADR_I(m_adr[1]), .M1_DAT_I(m_wdat[1]), .M1_SEL_I(m_sel[1]),
    .M1_DAT_O(m1_rdat), .M1_ACK_O(m1_ack), .M1_ERR_O(m1_err),
    .S_CYC_O(s_cyc), .S_STB_O(s_stb), .S_WE_O(s_we),
    .S_ADR_O(s_adr), .S_DAT_O(s_dat), .S_SEL_O(s_sel),
    .S_DAT_I(s_rdat), .S_ACK_I(s_ack), .S_ERR_I(s_err),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_q [$];   // expected S_ADR_O of each acked cycle, in grant order
  bit            slave_en;

  // Master 0 uses addresses below 0x1000_0000, master 1 has bit 28 set.
  function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : (a ^ 32'h5A5A_5A5A);
  endfunction

  // Slave model: zero-wait ACK one clock after it sees a fresh strobe.
  initial begin
    s_ack = 1'b0; s_err = 1'b0; s_rdat = '0;
    forever begin
      @(posedge clk); #1;
      if (slave_en && s_cyc && s_stb && !s_ack) begin
        s_ack = 1'b1; s_rdat = rd_model(s_adr);
      end else begin
        s_ack = 1'b0; s_rdat = '0;
      end
    end
  end

  // Scoreboard: every completed slave cycle pops one expected entry.
  initial begin
    logic [DW-1:0] e;
    logic          gid;
    forever begin
      @(negedge clk);
      if (s_cyc && s_ack) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL sb_unexpected: ack at adr %h, expected none", s_adr);
        end else begin
          e = exp_q.pop_front();
          gid = e[28];
          if (s_adr !== e) begin n_err++; $display("FAIL sb_order: adr %h, expected %h", s_adr, e); end
          if ((gid == 1'b0) ? (m0_ack !== 1'b1 || m1_ack !== 1'b0) : (m1_ack !== 1'b1 || m0_ack !== 1'b0)) begin
            n_err++; $display("FAIL sb_route: ack0=%b ack1=%b, expected owner m%0d only", m0_ack, m1_ack, gid);
          end
          if (((gid == 1'b0) ? m0_rdat : m1_rdat) !== rd_model(e)) begin
            n_err++; $display("FAIL sb_data: m%0d dat %h, expected %h", gid, (gid == 1'b0) ? m0_rdat : m1_rdat, rd_model(e));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic m_drive(input int m, input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    m_cyc[m] = 1'b1; m_stb[m] = 1'b1; m_we[m] = we;
    m_adr[m] = adr; m_wdat[m] = dat; m_sel[m] = '1;
  endtask

  task automatic m_idle(input int m);
    m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0;
    m_adr[m] = '0; m_wdat[m] = '0; m_sel[m] = '0;
  endtask

  // Wait (bounded) for ACK on master m, then drop STB and optionally CYC.
  task automatic m_wait(input int m, input bit drop);
    bit got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if ((m == 0) ? m0_ack : m1_ack) got = 1'b1;
    end
    n_vec++;
    if (!got) begin n_err++; $display("FAIL m%0d_ack_wait: no ACK within 60 cycles, expected one", m); end
    #1;
    m_stb[m] = 1'b0;
    if (drop) m_cyc[m] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #7;
    rst = 1'b0;
    @(posedge clk); #2;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_vec++; if (s_cyc !== 1'b0 || s_stb !== 1'b0 || s_adr !== '0) begin n_err++; $display("FAIL rst_slave: cyc=%b stb=%b adr=%h, expected 0", s_cyc, s_stb, s_adr); end
    n_vec++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL rst_state: %0d, expected %0d", dbg_state, IDLE); end
    n_vec++; if ({m0_ack, m1_ack, m0_err, m1_err} !== 4'b0) begin n_err++; $display("FAIL rst_resp: %b, expected 0000", {m0_ack, m1_ack, m0_err, m1_err}); end
    m_drive(0, 1'b0, 32'h20, '0);
    m_drive(1, 1'b0, 32'h1000_0020, '0);
    @(posedge clk); #2;
    n_vec++; if (s_cyc !== 1'b0 || dbg_state !== IDLE) begin n_err++; $display("FAIL rst_hold: cyc=%b state=%0d, expected 0/IDLE", s_cyc, dbg_state); end
    m_idle(0); m_idle(1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic test_m0_read();
    m_drive(0, 1'b0, 32'h10, '0);
    exp_q.push_back(32'h10);
    n_vec++; if (s_cyc !== 1'b0) begin n_err++; $display("FAIL rd_early: S_CYC_O=%b before edge, expected 0", s_cyc); end
    @(posedge clk); #2;
    n_vec++; if (s_cyc !== 1'b1 || dbg_state !== GRANT0) begin n_err++; $display("FAIL rd_latency: cyc=%b state=%0d, expected 1/GRANT0", s_cyc, dbg_state); end
    n_vec++; if (s_adr !== 32'h10 || s_we !== 1'b0) begin n_err++; $display("FAIL rd_mux: adr=%h we=%b, expected 00000010/0", s_adr, s_we); end
    m_wait(0, 1'b1);
    @(posedge clk); #2;
    n_vec++; if (dbg_state !== IDLE || s_cyc !== 1'b0) begin n_err++; $display("FAIL rd_release: state=%0d cyc=%b, expected IDLE/0", dbg_state, s_cyc); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    m_drive(0, 1'b0, 32'h0000_0100, '0);
    m_drive(1, 1'b0, 32'h1000_0200, '0);
    exp_q.push_back(32'h0000_0100);
    exp_q.push_back(32'h1000_0200);
    @(posedge clk); #2;
    n_vec++; if (dbg_state !== GRANT0 || s_adr !== 32'h0000_0100) begin n_err++; $display("FAIL tie_first: state=%0d adr=%h, expected GRANT0/00000100", dbg_state, s_adr); end
    m_wait(0, 1'b1);
    @(posedge clk); #2;
    n_vec++; if (dbg_state !== GRANT1 || s_adr !== 32'h1000_0200) begin n_err++; $display("FAIL tie_handover: state=%0d adr=%h, expected GRANT1/10000200", dbg_state, s_adr); end
    m_wait(1, 1'b1);
    @(posedge clk); #2;
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'h0000_0400 + 32'(i * 4));
      exp_q.push_back(32'h1000_0400 + 32'(i * 4));
    end
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          m_drive(0, 1'b0, 32'h0000_0400 + 32'(i * 4), '0);
          m_wait(0, 1'b1);
          @(posedge clk); #2;
        end
      end
      begin
        for (int j = 0; j < 4; j++) begin
          m_drive(1, 1'b0, 32'h1000_0400 + 32'(j * 4), '0);
          m_wait(1, 1'b1);
          @(posedge clk); #2;
        end
      end
    join
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rr_drain: %0d entries left, expected 0", exp_q.size()); end
  endtask

  task automatic test_grant_hold();
    logic [DW-1:0] wd;
    for (int k = 0; k < 3; k++) exp_q.push_back(32'h0000_0800 + 32'(k * 4));
    exp_q.push_back(32'h1000_0800);
    m_drive(0, 1'b1, 32'h0000_0800, 32'h1111_0000);
    @(posedge clk); #2;
    n_vec++; if (dbg_state !== GRANT0) begin n_err++; $display("FAIL hold_grant: state=%0d, expected GRANT0", dbg_state); end
    m_drive(1, 1'b0, 32'h1000_0800, '0);
    for (int k = 0; k < 3; k++) begin
      wd = 32'h1111_0000 + 32'(k);
      if (k > 0) m_drive(0, 1'b1, 32'h0000_0800 + 32'(k * 4), wd);
      #1;
      n_vec++; if (s_dat !== wd || s_we !== 1'b1 || s_sel !== 4'hF) begin n_err++; $display("FAIL hold_wdata%0d: dat=%h we=%b sel=%h, expected %h/1/f", k, s_dat, s_we, s_sel, wd); end
      m_wait(0, k == 2);
      n_vec++; if (m1_ack !== 1'b0) begin n_err++; $display("FAIL hold_m1ack%0d: %b, expected 0", k, m1_ack); end
      @(posedge clk); #2;
      if (k < 2) begin
        n_vec++; if (dbg_state !== GRANT0 || s_cyc !== 1'b1 || s_stb !== 1'b0) begin n_err++; $display("FAIL hold_keep%0d: state=%0d cyc=%b stb=%b, expected GRANT0/1/0", k, dbg_state, s_cyc, s_stb); end
      end
    end
    n_vec++; if (dbg_state !== GRANT1 || s_adr !== 32'h1000_0800) begin n_err++; $display("FAIL hold_release: state=%0d adr=%h, expected GRANT1/10000800", dbg_state, s_adr); end
    m_wait(1, 1'b1);
    @(posedge clk); #2;
  endtask

  task automatic test_async_reset();
    slave_en = 1'b0;
    m_drive(1, 1'b1, 32'h1000_0C00, 32'h2222_2222);
    @(posedge clk); #2;
    n_vec++; if (dbg_state !== GRANT1 || s_cyc !== 1'b1) begin n_err++; $display("FAIL arst_pre: state=%0d cyc=%b, expected GRANT1/1", dbg_state, s_cyc); end
    #1;
    rst = 1'b1;
    #1;
    n_vec++; if (s_cyc !== 1'b0 || s_stb !== 1'b0 || m1_ack !== 1'b0) begin n_err++; $display("FAIL arst_async: cyc=%b stb=%b ack1=%b, expected 0", s_cyc, s_stb, m1_ack); end
    n_vec++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL arst_state: %0d, expected IDLE", dbg_state); end
    m_idle(1);
    #2;
    rst = 1'b0;
    @(posedge clk); #2;
    slave_en = 1'b1;
    m_drive(0, 1'b0, 32'h0000_0C00, '0);
    m_drive(1, 1'b0, 32'h1000_0C04, '0);
    exp_q.push_back(32'h0000_0C00);
    exp_q.push_back(32'h1000_0C04);
    @(posedge clk); #2;
    n_vec++; if (dbg_state !== GRANT0) begin n_err++; $display("FAIL arst_tie: state=%0d, expected GRANT0", dbg_state); end
    m_wait(0, 1'b1);
    @(posedge clk); #2;
    n_vec++; if (dbg_state !== GRANT1) begin n_err++; $display("FAIL arst_next: state=%0d, expected GRANT1", dbg_state); end
    m_wait(1, 1'b1);
    @(posedge clk); #2;
  endtask

  task automatic test_timeout();
    slave_en = 1'b0;
    m_drive(0, 1'b0, 32'h0000_0F00, '0);
    @(posedge clk); #2;
`ifdef WB_ARB_TIMEOUT_EN
    for (int c = 0; c < 4; c++) begin
      n_vec++; if (s_cyc !== 1'b1 || m0_err !== 1'b0) begin n_err++; $display("FAIL to_stall%0d: cyc=%b err=%b, expected 1/0", c, s_cyc, m0_err); end
      @(posedge clk); #2;
    end
    n_vec++; if (m0_err !== 1'b1 || m1_err !== 1'b0) begin n_err++; $display("FAIL to_err: err0=%b err1=%b, expected 1/0", m0_err, m1_err); end
    n_vec++; if (s_cyc !== 1'b0 || s_stb !== 1'b0) begin n_err++; $display("FAIL to_force: cyc=%b stb=%b, expected 0/0", s_cyc, s_stb); end
    m_idle(0);
    @(posedge clk); #2;
    n_vec++; if (m0_err !== 1'b0 || dbg_state !== IDLE) begin n_err++; $display("FAIL to_after: err=%b state=%0d, expected 0/IDLE", m0_err, dbg_state); end
`else
    for (int c = 0; c < 100; c++) begin
      n_vec++; if (m0_err !== 1'b0 || s_cyc !== 1'b1) begin n_err++; $display("FAIL to_none%0d: err=%b cyc=%b, expected 0/1", c, m0_err, s_cyc); end
      @(posedge clk); #2;
    end
    m_idle(0);
    @(posedge clk); #2;
`endif
    slave_en = 1'b1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    slave_en = 1'b1;
    m_idle(0); m_idle(1);
    test_reset();
    test_m0_read();
    test_simultaneous();
    test_round_robin();
    test_grant_hold();
    test_async_reset();
    test_timeout();
    repeat (2) @(posedge clk);
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL final_drain: %0d entries left, expected 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
